// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, step width and
// sizing helpers used by the controller and its combinational step stage.
package div_seq_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam int unsigned STEP_BITS = 4;

   function automatic int unsigned step_count(input int unsigned width);
      return (width + STEP_BITS - 1) / STEP_BITS;
   endfunction

   // Signed bit-index width: must hold width-1 down to -STEP_BITS.
   function automatic int unsigned idx_width(input int unsigned width);
      return $clog2(width) + 2;
   endfunction

endpackage

// File: rtl/div_seq_ctrl_step4.sv
// Combinational radix-16 restoring step: resolves up to four quotient bits,
// from bit index i downwards, skipping indices below zero.
module div_step4
   import div_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned IW    = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0]        n,
   input  logic [WIDTH-1:0]        d,
   input  logic [WIDTH-1:0]        r,
   input  logic [WIDTH-1:0]        q,
   input  logic signed [IW-1:0]    i,
   output logic [WIDTH-1:0]        r_o,
   output logic [WIDTH-1:0]        q_o,
   output logic signed [IW-1:0]    i_o
);

   localparam int unsigned KW = $clog2(WIDTH);

   logic [WIDTH:0]   rp;
   logic [WIDTH-1:0] r_cur;
   logic [KW-1:0]    kb;
   int               k;

   always_comb begin
      r_cur = r;
      q_o   = q;
      rp    = '0;
      kb    = '0;
      k     = 0;
      for (int unsigned s = 0; s < STEP_BITS; s++) begin
         k = int'(i) - int'(s);
         if (k >= 0) begin
            kb = k[KW-1:0];
            // One extra bit keeps the shifted-out MSB of the partial remainder.
            rp = {r_cur, n[kb]};
            if (rp >= {1'b0, d}) begin
               rp      = rp - {1'b0, d};
               q_o[kb] = 1'b1;
            end else begin
               q_o[kb] = 1'b0;
            end
            r_cur = rp[WIDTH-1:0];
         end
      end
      r_o = r_cur;
   end

   assign i_o = i - $signed(IW'(STEP_BITS));

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential unsigned divider controller: captures N/D on start, iterates the
// four-bit restoring step in RUN, and presents Q/R with a one-cycle done.
module div_seq_ctrl
   import div_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned IW = idx_width(WIDTH);

   logic [1:0]              state;
   logic [WIDTH-1:0]        n_q, d_q, r_q, q_q;
   logic signed [IW-1:0]    i_q;
   logic [WIDTH-1:0]        r_nx, q_nx;
   logic signed [IW-1:0]    i_nx;
   logic                    accept;

   div_step4 #(.WIDTH(WIDTH), .IW(IW)) u_step (
      .n   (n_q),
      .d   (d_q),
      .r   (r_q),
      .q   (q_q),
      .i   (i_q),
      .r_o (r_nx),
      .q_o (q_nx),
      .i_o (i_nx)
   );

   assign accept = start && (state == ST_IDLE || state == ST_FIN);
   assign busy   = (state == ST_RUN);
   assign done   = (state == ST_FIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         n_q         <= '0;
         d_q         <= '0;
         r_q         <= '0;
         q_q         <= '0;
         i_q         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               r_q <= r_nx;
               q_q <= q_nx;
               i_q <= i_nx;
               if (i_q < $signed(IW'(STEP_BITS))) begin
                  quotient  <= q_nx;
                  remainder <= r_nx;
                  state     <= ST_FIN;
               end
            end
            ST_IDLE, ST_FIN: begin
               if (accept) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= ST_FIN;
                  end else begin
                     n_q         <= dividend;
                     d_q         <= divisor;
                     r_q         <= '0;
                     q_q         <= '0;
                     i_q         <= $signed(IW'(WIDTH - 1));
                     div_by_zero <= 1'b0;
                     state       <= ST_RUN;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed scenarios plus a random sweep
// against a plain / and % reference model.
module tb_div_seq_ctrl;

   localparam int W     = 10;
   localparam int STEPS = (W + 3) / 4;
   localparam int MAXV  = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int checks = 0;
   int errors = 0;

   div_seq_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues one request at the current negedge and follows it to done.
   task automatic run_op(input int n, input int d, input bit pulse_mid);
      int cycles, busy_cnt, exp_q, exp_r, exp_lat;
      exp_q   = (d == 0) ? MAXV : n / d;
      exp_r   = (d == 0) ? n : n % d;
      exp_lat = (d == 0) ? 1 : STEPS + 1;
      dividend = W'(n);
      divisor  = W'(d);
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      cycles   = 1;
      busy_cnt = 0;
      chk("busy_after_start", {31'd0, busy}, (d != 0) ? 1 : 0);
      while (!done && cycles < 40) begin
         if (busy) busy_cnt++;
         if (pulse_mid && cycles == 1) begin
            start    = 1'b1;
            dividend = W'(9);
            divisor  = W'(9);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      chk("done_seen", {31'd0, done}, 1);
      chk("latency", cycles, exp_lat);
      chk("busy_cycles", busy_cnt, (d == 0) ? 0 : STEPS);
      chk("busy_in_fin", {31'd0, busy}, 0);
      chk("quotient", {22'd0, quotient}, exp_q);
      chk("remainder", {22'd0, remainder}, exp_r);
      chk("div_by_zero", {31'd0, div_by_zero}, (d == 0) ? 1 : 0);
   endtask

   task automatic idle_after;
      @(negedge clk);
      chk("done_single_pulse", {31'd0, done}, 0);
   endtask

   initial begin
      int n, d;
      #2;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_quotient", {22'd0, quotient}, 0);
      chk("rst_remainder", {22'd0, remainder}, 0);
      chk("rst_dbz", {31'd0, div_by_zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(10, 5, 1'b0);
      idle_after();

      run_op(86, 14, 1'b0);
      run_op(1023, 1, 1'b0);
      idle_after();

      run_op(100, 0, 1'b0);
      idle_after();
      chk("dbz_held", {31'd0, div_by_zero}, 1);
      run_op(7, 3, 1'b0);
      idle_after();

      run_op(500, 7, 1'b1);
      idle_after();

      // Abort a division in flight with an asynchronous reset.
      dividend = W'(999);
      divisor  = W'(10);
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_done", {31'd0, done}, 0);
      chk("abort_quotient", {22'd0, quotient}, 0);
      chk("abort_remainder", {22'd0, remainder}, 0);
      chk("abort_dbz", {31'd0, div_by_zero}, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_abort_no_done", {31'd0, done}, 0);
      end
      run_op(999, 10, 1'b0);
      idle_after();

      for (int t = 0; t < 1000; t++) begin
         n = int'($urandom_range(MAXV, 0));
         d = (($urandom % 16) == 0) ? 0 : int'($urandom_range(MAXV, 1));
         run_op(n, d, ($urandom % 4) == 0);
         if (($urandom % 2) == 0) idle_after();
      end
      idle_after();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
